// File: rtl/debounce_pkg.sv
// Shared types and elaboration-time helpers for the debounce delay timer.
// Holds the FSM state encoding and the functions that derive the prescale
// ratio and counter widths from the clock and tick parameters.
package debounce_pkg;

  // FSM state encoding. 2'b11 is unused and treated as illegal.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Number of clock cycles per prescaled tick.
  function automatic int calc_prescale(input int clk_freq_hz, input int tick_hz);
    return clk_freq_hz / tick_hz;
  endfunction

  // Counter width able to hold 0 .. n-1, with one bit of headroom.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/debounce_delay_timer_if.sv
// Handshake between the push-button debouncer FSM (master) and the
// delay timer (slave). The debouncer drives clr from its rst_out and
// watches fin_delay to leave its wait state.
interface debounce_delay_timer_if;

  logic clr;
  logic fin_delay;
  logic busy;
  logic tick;

  modport master (
    output clr,
    input  fin_delay,
    input  busy,
    input  tick
  );

  modport slave (
    input  clr,
    output fin_delay,
    output busy,
    output tick
  );

endinterface

// File: rtl/tick_prescaler.sv
// Wrapping prescale counter. While en is high it counts 0..PRESCALE-1 and
// flags the wrap cycle on tick; while en is low the counter is held at 0.
// tick is a same-cycle strobe so the parent can act on the wrapping edge
// and register its own observable tick output.
module tick_prescaler
  import debounce_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW   = cnt_width(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count while enabled, wrap at LAST, hold at zero when disabled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/debounce_delay_timer.sv
// Debounce window timer. While clr is low it runs for DELAY_TICKS prescaled
// ticks, then raises fin_delay and holds it until clr returns high. A clr
// pulse mid-window throws away all progress and the next run starts from
// zero. rst is synchronous, active-low, and overrides clr.
module debounce_delay_timer
  import debounce_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int TICK_HZ     = 1000,
  parameter int DELAY_TICKS = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  debounce_delay_timer_if.slave  bus
);

  localparam int            PRESCALE = calc_prescale(CLK_FREQ_HZ, TICK_HZ);
  localparam int            TW       = cnt_width(DELAY_TICKS);
  localparam logic [TW-1:0] TLAST    = TW'(DELAY_TICKS - 1);

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic          fin_q;
  logic          busy_q;
  logic          tick_q;
  logic          pre_en;
  logic          pre_tick;

  // The prescaler only runs in COUNT with clr low; everywhere else it sits
  // at zero, so a fresh window always starts with a full first tick period.
  assign pre_en = (state == COUNT) && !bus.clr;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .tick (pre_tick)
  );

  assign bus.fin_delay = fin_q;
  assign bus.busy      = busy_q;
  assign bus.tick      = tick_q;

  // Window FSM and tick counter; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      fin_q    <= 1'b0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else if (bus.clr) begin
      state    <= IDLE;
      tick_cnt <= '0;
      fin_q    <= 1'b0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= COUNT;
          tick_cnt <= '0;
          fin_q    <= 1'b0;
          busy_q   <= 1'b1;
          tick_q   <= 1'b0;
        end
        COUNT: begin
          tick_q <= pre_tick;
          if (pre_tick) begin
            if (tick_cnt == TLAST) begin
              // Final tick: fin_delay rises on this same edge.
              state  <= DONE;
              fin_q  <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          fin_q  <= 1'b1;
          busy_q <= 1'b0;
          tick_q <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
          fin_q    <= 1'b0;
          busy_q   <= 1'b0;
          tick_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_delay_timer.sv
// Testbench for debounce_delay_timer with PRESCALE=4, DELAY_TICKS=3.
// Reference model: n = number of consecutive edges sampling rst=1, clr=0.
// From that count alone: busy while 1<=n<=12, tick when n-1 is a positive
// multiple of 4 up to 12, fin_delay once n>12.
module tb_debounce_delay_timer;

  localparam int P   = 4;
  localparam int DT  = 3;
  localparam int WIN = P * DT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr_tb = 1'b1;
  logic sw = 1'b0;
  logic loop_mode = 1'b0;
  logic deb_rst_out;

  int tests = 0;
  int fails = 0;
  int n = 0;
  int shots;

  typedef enum int {D_IDLE, D_WAIT, D_PULSE, D_HOLD} dst_t;
  dst_t dst;

  always #5 clk = ~clk;

  debounce_delay_timer_if bus ();

  debounce_delay_timer #(
    .CLK_FREQ_HZ (4),
    .TICK_HZ     (1),
    .DELAY_TICKS (DT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Simple push-button debouncer: waits on fin_delay, then emits one pulse.
  assign deb_rst_out = (dst != D_WAIT);
  assign bus.clr     = loop_mode ? deb_rst_out : clr_tb;

  always @(posedge clk) begin
    if (!rst) begin
      dst   <= D_IDLE;
      shots <= 0;
    end else begin
      if (dst == D_PULSE) shots <= shots + 1;
      case (dst)
        D_IDLE:  if (sw) dst <= D_WAIT;
        D_WAIT:  if (bus.fin_delay) dst <= D_PULSE;
        D_PULSE: dst <= D_HOLD;
        D_HOLD:  if (!sw) dst <= D_IDLE;
        default: dst <= D_IDLE;
      endcase
    end
  end

  function automatic logic exp_fin(input int k);
    return k > WIN;
  endfunction

  function automatic logic exp_busy(input int k);
    return (k >= 1) && (k <= WIN);
  endfunction

  function automatic logic exp_tick(input int k);
    return (k >= 2) && (k <= WIN + 1) && (((k - 1) % P) == 0);
  endfunction

  task automatic check(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b (n=%0d)", tag, obs, expv, n);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock edge: drive, sample inputs mid-cycle, advance model, compare.
  task automatic cyc(input logic r, input logic c);
    logic rs, cs;
    rst    = r;
    clr_tb = c;
    @(negedge clk);
    rs = rst;
    cs = bus.clr;
    @(posedge clk);
    #1;
    if (!rs || cs) n = 0;
    else n++;
    check("fin_delay", bus.fin_delay, exp_fin(n));
    check("busy", bus.busy, exp_busy(n));
    check("tick", bus.tick, exp_tick(n));
  endtask

  // Run with rst=1, clr_tb=0 until fin_delay is seen, bounded.
  task automatic run_until_fin(output int k);
    k = 0;
    while (!bus.fin_delay && k < 40) begin
      cyc(1'b1, 1'b0);
      k++;
    end
  endtask

  initial begin
    int k;
    int wait_cycles;

    // Reset held low with clr low: everything stays zero.
    repeat (3) cyc(1'b0, 1'b0);

    // Nominal window: E0 is the first released edge.
    cyc(1'b1, 1'b0);
    run_until_fin(k);
    check_int("nominal_latency", k, WIN);
    repeat (20) cyc(1'b1, 1'b0);

    // Clear from DONE, then a second full window.
    cyc(1'b1, 1'b1);
    check("clear_fin_low", bus.fin_delay, 1'b0);
    cyc(1'b1, 1'b0);
    run_until_fin(k);
    check_int("rewindow_latency", k, WIN);

    // Mid-window restart: clr pulse at E6 restarts from E7.
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    repeat (5) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    run_until_fin(k);
    check_int("restart_abs_edge", 7 + k, 19);

    // Reset for one cycle at E5 while clr stays low.
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    repeat (4) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check("midreset_busy", bus.busy, 1'b0);
    cyc(1'b1, 1'b0);
    run_until_fin(k);
    check_int("midreset_latency", k, WIN);

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 29) == 0));
    end

    // Closed loop with the debouncer driving clr.
    loop_mode = 1'b1;
    sw = 1'b0;
    cyc(1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0);
    wait_cycles = 0;
    sw = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i >= 2 && i < 10) sw = logic'($urandom_range(0, 1));
      else if (i >= 10 && i < 20) sw = 1'b1;
      else if (i >= 20) sw = 1'b0;
      cyc(1'b1, 1'b0);
      if (dst == D_WAIT) wait_cycles++;
    end
    check_int("loop_wait_cycles", wait_cycles, WIN + 2);
    check_int("loop_one_shots", shots, 1);
    loop_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
